hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage ID-stage hazard detector.
- Replaces pipeline-register compares with a per-register countdown scoreboard, so it covers configurable load latency and a multi-cycle MUL/DIV unit (HI/LO busy).
- Sits beside ID.
- Drives the stall to PC/IF-ID and the flush to IF-ID; consumes decoded ID fields plus a global memory freeze.

Parameters:
- NUM_REGS, 32, architectural GPR count (reg 0 hard-wired zero, never tracked).
- REG_AW, $clog2(NUM_REGS), register index width.
- LOAD_LAT, 1, extra cycles after EX before load data is forwardable (1 = classic MEM-stage load).
- MDU_LAT, 4, cycles the MUL/DIV unit is busy after issue.
- CNT_W, $clog2(LOAD_LAT+2)+1, scoreboard counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- mem_stall  in  1  global freeze; scoreboard and MDU counter hold.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source register 1.
- id_rt  in  REG_AW  source register 2.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_rd  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes id_rd.
- id_is_load  in  1  destination produced by memory.
- id_branch  in  1  conditional branch resolved in ID.
- id_zero  in  1  branch condition true.
- id_pcsrc  in  2  00 seq, 01 j/jal, 1x jr/jalr (reads rs in ID).
- id_mdu_start  in  1  mult/div issue.
- id_hilo_read  in  1  mfhi/mflo.
- stall  out  1  hold PC and IF/ID, bubble into EX.
- if_flush  out  1  squash IF/ID.
- stall_cause  out  3  one-hot {mdu, id_resolve, load_use}; 0 when no stall.
- perf_stall_cycles  out  32  optional counter.
- perf_load_use  out  32  optional counter.

Behaviour:
- Reset (rst_n=0 at posedge): all cnt[r]=0, mdu_cnt=0, perf counters 0. stall, if_flush and stall_cause are combinational and evaluate to 0 afterwards, given idle inputs.
- Scoreboard: cnt[r] for r in 1..NUM_REGS-1. Each unfrozen cycle, every nonzero cnt decrements by 1, saturating at 0.
- issue = id_valid & ~stall & ~mem_stall.
- On issue with id_reg_write & id_rd!=0: cnt[id_rd] <= id_is_load ? LOAD_LAT+1 : 1. Issue load overrides the decrement of the same entry in the same cycle.
- needs_id = id_branch | id_pcsrc[1].
- load_use when any used source s has cnt[s] > 1 and ~needs_id.
- id_resolve when needs_id and any used source s has cnt[s] > 0. Sources are rs/rt for a branch, rs only for jr.
- Source index 0 never hazards.
- mdu hazard when mdu_cnt != 0 and (id_mdu_start | id_hilo_read).
- On issue with id_mdu_start: mdu_cnt <= MDU_LAT; otherwise mdu_cnt decrements to 0.
- stall = id_valid & (load_use | id_resolve | mdu). Priority for stall_cause: mdu > id_resolve > load_use; exactly one bit set.
- if_flush = id_valid & ~stall & ((id_branch & id_zero) | id_pcsrc != 00). It is never asserted with stall.
- mem_stall=1: no counter changes, no issue. stall/if_flush are still driven combinationally and are ignored by the pipeline.
- Resulting latencies with LOAD_LAT=1:
  - ALU -> ALU: 0 bubbles.
  - ALU -> branch: 1 bubble.
  - load -> ALU: 1 bubble.
  - load -> branch: 2 bubbles.
- Reset mid-countdown clears all pending state immediately.

Optional Feature:
- HAZARD_PERF_EN defined:
  - perf_stall_cycles increments on each cycle with stall & ~mem_stall.
  - perf_load_use increments on the first stall cycle of each load_use episode (rising edge of cause bit). Counters wrap at 2^32.
- Undefined: both outputs tied to 0, no flops.

Decomposition:
- Shared package hazard_pkg holds:
  - cause bit indices CAUSE_LOAD_USE=0, CAUSE_ID_RESOLVE=1, CAUSE_MDU=2;
  - PCSRC_SEQ/J/JR encodings;
  - the default LOAD_LAT and MDU_LAT constants.
- One natural sub-module: sb_counter (single saturating down-counter entry with load/hold), instantiated NUM_REGS-1 times via generate.

Test Plan:
- lw $3 issued, next ID add $4,$3,$5 (uses_rs) -> stall=1, cause=001 for exactly 1 cycle, then issue.
- add $3 issued, next beq $3,$0 -> 1 stall cycle, cause=010. Then with id_zero=1: if_flush=1 in the following cycle, stall=0.
- lw $3 then jr $3 -> 2 stall cycles (cause=010), then if_flush=1. Repeat with LOAD_LAT=3 -> 4 stall cycles.
- mult issued, mfhi next with MDU_LAT=4 -> stall 4 cycles, cause=100. During it, assert mem_stall 2 cycles -> total stall extended to 6.
- add $0 then beq $0 -> no stall. lw $3 with uses_rs=0 for $3 -> no stall.
- rst_n=0 while cnt[3]=2 -> next cycle dependent add issues with stall=0. With HAZARD_PERF_EN, perf_stall_cycles reads 0 after reset and equals the total stall count afterwards.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: stall-cause bit
// positions, PC-source encodings and default pipeline latencies.
package hazard_pkg;

    // Bit positions inside the one-hot stall_cause vector.
    localparam int CAUSE_LOAD_USE   = 0;
    localparam int CAUSE_ID_RESOLVE = 1;
    localparam int CAUSE_MDU        = 2;
    localparam int CAUSE_W          = 3;

    // id_pcsrc encodings; any value with bit 1 set is a register jump.
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_J   = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;

    // Default latencies: classic MEM-stage load, 4-cycle MUL/DIV.
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MDU_LAT  = 4;

    // Collapse the three raw hazard flags into a one-hot cause,
    // highest priority first: mdu > id_resolve > load_use.
    function automatic logic [CAUSE_W-1:0] cause_encode(
        input logic mdu,
        input logic id_resolve,
        input logic load_use
    );
        logic [CAUSE_W-1:0] c;
        c = '0;
        if (mdu) begin
            c[CAUSE_MDU] = 1'b1;
        end else if (id_resolve) begin
            c[CAUSE_ID_RESOLVE] = 1'b1;
        end else if (load_use) begin
            c[CAUSE_LOAD_USE] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// sb_counter: one scoreboard entry. Counts down to zero, can be loaded with
// a new latency, and holds its value while the pipeline is frozen.
module sb_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next value: freeze wins, then a fresh load, then saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Entry register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage hazard detector built on a per-register
// countdown scoreboard plus a MUL/DIV busy counter. Produces stall and
// IF/ID flush, and a one-hot stall cause.
// Optional feature macro: HAZARD_PERF_EN adds the two performance counters;
// without it the perf outputs are constant zero and no flops are built.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MDU_LAT  = DEF_MDU_LAT,
    parameter int CNT_W    = $clog2(LOAD_LAT + 2) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_branch,
    input  logic              id_zero,
    input  logic [1:0]        id_pcsrc,
    input  logic              id_mdu_start,
    input  logic              id_hilo_read,
    output logic              stall,
    output logic              if_flush,
    output logic [CAUSE_W-1:0] stall_cause,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_load_use
);

    localparam int MDU_W = $clog2(MDU_LAT + 1);

    // Cycles until each register's producer result can be forwarded.
    // Entry 0 is the hard-wired zero register and never waits.
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] load_val;
    logic             issue;
    logic             needs_id;
    logic             rs_live;
    logic             rt_live;
    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic             load_use_hz;
    logic             id_res_hz;
    logic             mdu_hz;
    logic [MDU_W-1:0] mdu_cnt_q;
    logic [MDU_W-1:0] mdu_cnt_d;

    assign cnt[0]   = '0;
    assign issue    = id_valid & ~stall & ~mem_stall;
    assign load_val = id_is_load ? CNT_W'(LOAD_LAT + 1) : CNT_W'(1);

    // One countdown entry per trackable register.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        sb_counter #(
            .W(CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .hold_i     (mem_stall),
            .load_i     (issue & id_reg_write & (id_rd == REG_AW'(r))),
            .load_val_i (load_val),
            .cnt_o      (cnt[r])
        );
    end

    // Hazard detection. An ALU consumer in ID can take a forwarded value
    // when its count is 1 (producer in EX), so only counts above 1 stall it.
    // Branches and register jumps resolve in ID and need the value settled.
    always_comb begin
        needs_id    = id_branch | id_pcsrc[1];
        rs_live     = (id_rs != '0);
        rt_live     = (id_rt != '0);
        rs_cnt      = cnt[id_rs];
        rt_cnt      = cnt[id_rt];
        load_use_hz = ~needs_id &
                      ((id_uses_rs & rs_live & (rs_cnt > CNT_W'(1))) |
                       (id_uses_rt & rt_live & (rt_cnt > CNT_W'(1))));
        id_res_hz   = needs_id &
                      (((id_uses_rs | id_pcsrc[1]) & rs_live & (rs_cnt != '0)) |
                       (id_branch & id_uses_rt & rt_live & (rt_cnt != '0)));
        mdu_hz      = (mdu_cnt_q != '0) & (id_mdu_start | id_hilo_read);
    end

    // Stall, cause and flush outputs; flush is suppressed while stalling.
    always_comb begin
        stall       = id_valid & (load_use_hz | id_res_hz | mdu_hz);
        stall_cause = '0;
        if (stall) begin
            stall_cause = cause_encode(mdu_hz, id_res_hz, load_use_hz);
        end
        if_flush = id_valid & ~stall &
                   ((id_branch & id_zero) | (id_pcsrc != PCSRC_SEQ));
    end

    // MUL/DIV busy counter: reloads on issue, otherwise counts down.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (!mem_stall) begin
            if (issue & id_mdu_start) begin
                mdu_cnt_d = MDU_W'(MDU_LAT);
            end else if (mdu_cnt_q != '0) begin
                mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
            end
        end
    end

    // MUL/DIV busy register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdu_cnt_q <= '0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_lu_q;
    logic [31:0] perf_lu_d;
    logic        lu_prev_q;
    logic        lu_prev_d;

    // Count effective stall cycles and load-use episodes; a frozen cycle
    // neither counts nor ends an episode.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_lu_d    = perf_lu_q;
        lu_prev_d    = lu_prev_q;
        if (!mem_stall) begin
            lu_prev_d = stall_cause[CAUSE_LOAD_USE];
            if (stall) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
            if (stall_cause[CAUSE_LOAD_USE] & ~lu_prev_q) begin
                perf_lu_d = perf_lu_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_lu_q    <= '0;
            lu_prev_q    <= 1'b0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_lu_q    <= perf_lu_d;
            lu_prev_q    <= lu_prev_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_load_use     = perf_lu_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_load_use     = '0;
`endif

endmodule
